// File: rtl/imem_loader.sv
// Byte-stream program loader: parses A5-framed images from a host byte source,
// writes 32-bit words into instruction memory and holds the CPU in reset meanwhile.
module imem_loader #(
    parameter int ADDR_W  = 8,     // word-address width, 1..16
    parameter int TIMEOUT = 1000   // idle mid-frame cycles before abort, >= 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_written
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t             state_reg;
    logic [1:0]         byte_idx_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [15:0]        remain_reg;
    logic [31:0]        word_reg;
    logic [7:0]         csum_reg;
    logic [TMO_W-1:0]   tmo_reg;

    logic        accept;
    logic        mid_frame;
    logic        tmo_expire;
    logic [7:0]  csum_next;
    logic [15:0] count_next;
    logic [31:0] word_next;

    assign in_ready   = (state_reg != S_WRITE);
    assign accept     = in_valid && in_ready;
    assign mid_frame  = (state_reg == S_ADDR) || (state_reg == S_CNT) ||
                        (state_reg == S_DATA) || (state_reg == S_CSUM);
    assign tmo_expire = mid_frame && !accept && (tmo_reg == TMO_W'(TIMEOUT - 1));
    assign csum_next  = csum_reg ^ in_data;
    assign count_next = {remain_reg[7:0], in_data};
    assign word_next  = {word_reg[23:0], in_data};

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            byte_idx_reg  <= '0;
            addr_reg      <= '0;
            remain_reg    <= '0;
            word_reg      <= '0;
            csum_reg      <= '0;
            tmo_reg       <= '0;
            im_we         <= 1'b0;
            im_addr       <= '0;
            im_wdata      <= '0;
            cpu_hold      <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            words_written <= '0;
        end else begin
            im_we <= 1'b0;
            if (mid_frame) begin
                tmo_reg <= accept ? '0 : tmo_reg + 1'b1;
            end

            if (tmo_expire) begin
                // Abort: words already written stay in memory.
                state_reg <= S_ERR;
                load_err  <= 1'b1;
                cpu_hold  <= 1'b0;
                tmo_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (accept && in_data == 8'hA5) begin
                            state_reg     <= S_ADDR;
                            cpu_hold      <= 1'b1;
                            load_done     <= 1'b0;
                            load_err      <= 1'b0;
                            words_written <= '0;
                            csum_reg      <= '0;
                            byte_idx_reg  <= '0;
                            addr_reg      <= '0;
                            tmo_reg       <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (accept) begin
                            csum_reg     <= csum_next;
                            // Shifting through a truncating register keeps the low ADDR_W bits.
                            addr_reg     <= ADDR_W'({addr_reg, in_data});
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            if (byte_idx_reg == 2'd1) begin
                                byte_idx_reg <= '0;
                                state_reg    <= S_CNT;
                            end
                        end
                    end
                    S_CNT: begin
                        if (accept) begin
                            csum_reg     <= csum_next;
                            remain_reg   <= count_next;
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            if (byte_idx_reg == 2'd1) begin
                                byte_idx_reg <= '0;
                                state_reg    <= (count_next == 16'd0) ? S_CSUM : S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            csum_reg     <= csum_next;
                            word_reg     <= word_next;
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            if (byte_idx_reg == 2'd3) begin
                                state_reg <= S_WRITE;
                                im_we     <= 1'b1;
                                im_addr   <= addr_reg;
                                im_wdata  <= word_next;
                            end
                        end
                    end
                    S_WRITE: begin
                        addr_reg   <= addr_reg + 1'b1;
                        remain_reg <= remain_reg - 16'd1;
                        if (words_written != 16'hFFFF) begin
                            words_written <= words_written + 16'd1;
                        end
                        state_reg <= (remain_reg != 16'd1) ? S_DATA : S_CSUM;
                    end
                    S_CSUM: begin
                        if (accept) begin
                            cpu_hold <= 1'b0;
                            if (in_data == csum_reg) begin
                                state_reg <= S_DONE;
                                load_done <= 1'b1;
                            end else begin
                                state_reg <= S_ERR;
                                load_err  <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from a byte-level model,
// expected writes and frame outcomes are queued and checked by a monitor.
module tb_imem_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [15:0]       words_written;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .im_we         (im_we),
        .im_addr       (im_addr),
        .im_wdata      (im_wdata),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_written (words_written)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        bit done;
        bit err;
        int ww;
    } res_t;

    wr_t         wr_q[$];
    res_t        res_q[$];
    logic [31:0] stim_words[$];

    int   checks = 0;
    int   errors = 0;
    int   fall_cyc = 0;
    int   t_last = 0;
    bit   acc_last = 1'b0;
    logic hold_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever a write or a frame end is observed.
    always @(negedge CLK) begin
        if (reset) begin
            if (im_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", im_addr, im_wdata);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(im_addr), 32'(w.addr));
                    chk("wr_data", im_wdata, w.data);
                    chk("wr_ready_low", 32'(in_ready), 32'd0);
                    chk("wr_latency", 32'(acc_last), 32'd1);
                    $display("write addr=0x%02h data=0x%08h", im_addr, im_wdata);
                end
            end
            if (hold_prev && !cpu_hold) begin
                fall_cyc = cyc;
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_end: got done=%0b err=%0b expected none", load_done, load_err);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("res_done", 32'(load_done), 32'(r.done));
                    chk("res_err", 32'(load_err), 32'(r.err));
                    chk("res_words", 32'(words_written), 32'(r.ww));
                    $display("frame end done=%0b err=%0b words=%0d", load_done, load_err, words_written);
                end
            end
        end
        hold_prev = cpu_hold;
        acc_last  = in_valid && in_ready && reset;
    end

    // Inputs change 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] v);
        bit rdy;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        do begin
            rdy = in_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 20);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL ready_stuck: got in_ready=0 for %0d cycles expected 1", n);
        end
        t_last = cyc;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_res(input int t_exp);
        int n;
        n = 0;
        while (res_q.size() != 0 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (res_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_end_timeout: got no cpu_hold fall expected one by cycle %0d", t_exp);
            res_q.delete();
        end else begin
            chk("hold_fall_cycle", 32'(fall_cyc), 32'(t_exp));
        end
    endtask

    // csum_sel: -1 correct checksum, -2 random wrong one, 0..255 literal byte.
    // cut: number of frame bytes to send before going silent (-1 = whole frame).
    task automatic run_frame(input logic [15:0] start, input int csum_sel,
                             input int max_gap, input int cut);
        logic [7:0]  b[$];
        logic [7:0]  x;
        logic [7:0]  cb;
        logic [15:0] nn;
        logic [31:0] w;
        int          n, total, nwr, t_exp;
        bit          good;
        n  = stim_words.size();
        nn = 16'(n);
        b.push_back(8'hA5);
        b.push_back(start[15:8]);
        b.push_back(start[7:0]);
        b.push_back(nn[15:8]);
        b.push_back(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = stim_words[i];
            b.push_back(w[31:24]);
            b.push_back(w[23:16]);
            b.push_back(w[15:8]);
            b.push_back(w[7:0]);
        end
        x = 8'h00;
        for (int i = 1; i < b.size(); i++) x = x ^ b[i];
        if (csum_sel == -1)      cb = x;
        else if (csum_sel == -2) cb = x ^ 8'($urandom_range(1, 255));
        else                     cb = 8'(csum_sel);
        b.push_back(cb);

        total = (cut < 0) ? b.size() : cut;
        if (cut < 0)      nwr = n;
        else if (cut > 5) nwr = (cut - 5) / 4;
        else              nwr = 0;
        if (nwr > n) nwr = n;
        for (int i = 0; i < nwr; i++) begin
            wr_t e;
            e.addr = (int'(start) + i) % (1 << ADDR_W);
            e.data = stim_words[i];
            wr_q.push_back(e);
        end
        good = (cut < 0) && (cb == x);
        begin
            res_t r;
            r.done = good;
            r.err  = !good;
            r.ww   = nwr;
            res_q.push_back(r);
        end

        for (int i = 0; i < total; i++) begin
            send_byte(b[i]);
            if (max_gap > 0 && i < total - 1) idle($urandom_range(0, max_gap));
        end
        in_valid = 1'b0;

        if (cut < 0) t_exp = t_last;
        // The write cycle after a completed word does not count towards the timeout.
        else if (cut >= 9 && ((cut - 5) % 4) == 0) t_exp = t_last + TIMEOUT + 1;
        else t_exp = t_last + TIMEOUT;
        wait_res(t_exp);
        $display("frame start=0x%04h n=%0d sent=%0d good=%0b", start, n, total, good);
        stim_words.delete();
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        idle(2);

        // Basic load with in_valid held high and the literal checksum byte.
        stim_words.push_back(32'h20010005);
        stim_words.push_back(32'h0000FFFF);
        run_frame(16'h0010, 8'h36, 0, -1);

        // Empty frame.
        run_frame(16'h0000, 8'h00, 0, -1);

        // Address wrap with a wrong checksum.
        stim_words.push_back(32'h11111111);
        stim_words.push_back(32'h22222222);
        run_frame(16'h00FF, 8'h00, 0, -1);

        // Timeout after the address bytes, then a good frame clears the error.
        run_frame(16'h0010, -1, 0, 3);
        stim_words.push_back(32'hA5A5A5A5);
        run_frame(16'h0030, -1, 0, -1);

        // Garbage outside a frame is discarded.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        stim_words.push_back(32'hDEADBEEF);
        stim_words.push_back(32'h01234567);
        run_frame(16'h1234, -1, 0, -1);

        // Asynchronous reset between edges while a write strobe is high.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hF0);
        send_byte(8'h0D);
        chk("pre_rst_we", 32'(im_we), 32'd1);
        chk("pre_rst_wdata", im_wdata, 32'hCAFEF00D);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_rst_we", 32'(im_we), 32'd0);
        chk("async_rst_hold", 32'(cpu_hold), 32'd0);
        chk("async_rst_words", 32'(words_written), 32'd0);
        chk("async_rst_wdata", im_wdata, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        stim_words.push_back(32'h0BADF00D);
        run_frame(16'h0040, -1, 0, -1);

        // Randomized frames: gaps, wrap, bad checksums and truncations.
        for (int f = 0; f < 14; f++) begin
            int n, cs, ct;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) stim_words.push_back($urandom);
            cs = ($urandom_range(0, 3) == 0) ? -2 : -1;
            ct = -1;
            if (n > 0 && $urandom_range(0, 4) == 0) ct = $urandom_range(1, 5 + 4 * n);
            run_frame(16'($urandom), cs, 4, ct);
        end

        idle(5);
        chk("leftover_writes", 32'(wr_q.size()), 32'd0);
        chk("leftover_results", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
